// File: rtl/jtcop_pkg.sv
// jtcop_pkg: DMA sequencer state encoding and 68000 bus-handshake polarities shared by jtcop bus masters
package jtcop_pkg;
  typedef enum logic [2:0] {IDLE, REQ, GRANT, COPY, FLUSH, REL} dma_st_t;
  localparam logic BUS_ON  = 1'b0;
  localparam logic BUS_OFF = 1'b1;
endpackage

// File: rtl/jtcop_busreq.sv
// jtcop_busreq: BR/BG/BGACK handshake FSM that owns the 68000 bus for the duration of a DMA burst
module jtcop_busreq
  import jtcop_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       i_last,
  input  logic       i_asn,
  input  logic       i_bgn,
  output logic       o_brn,
  output logic       o_bgackn,
  output logic [2:0] o_st
);
  dma_st_t r_st, w_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= IDLE;
    else     r_st <= w_nx;
  end
  // the bus is only taken once the CPU has finished its current cycle (AS released)
  always_comb begin
    w_nx = r_st;
    case (r_st)
      IDLE:    w_nx = i_req ? REQ : IDLE;
      REQ:     w_nx = (i_bgn == BUS_ON && i_asn) ? GRANT : REQ;
      GRANT:   w_nx = i_last ? FLUSH : COPY;
      COPY:    w_nx = i_last ? FLUSH : COPY;
      FLUSH:   w_nx = REL;
      REL:     w_nx = i_req ? REQ : IDLE;
      default: w_nx = IDLE;
    endcase
  end
  assign o_brn    = (r_st == REQ || r_st == GRANT) ? BUS_ON : BUS_OFF;
  assign o_bgackn = (r_st == GRANT || r_st == COPY || r_st == FLUSH || r_st == REL) ? BUS_ON : BUS_OFF;
  assign o_st     = r_st;
endmodule

// File: rtl/jtcop_objdma.sv
// jtcop_objdma: once-per-frame copy of object RAM into the object chip buffer over a borrowed 68000 bus
module jtcop_objdma
  import jtcop_pkg::*;
#(
  parameter int AW  = 10,
  parameter int LEN = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          obj_copy,
  input  logic          ASn,
  input  logic          BGn,
  output logic          BRn,
  output logic          BGACKn,
  output logic [AW-1:0] ram_addr,
  input  logic [15:0]   ram_dout,
  output logic [AW-1:0] buf_addr,
  output logic [15:0]   buf_din,
  output logic          buf_we,
  output logic          busy,
  output logic          done
);
  localparam logic [AW-1:0] LAST = AW'(LEN - 1);
  logic [2:0]    w_st;
  logic          w_req, w_last;
  logic          r_pending;
  logic [AW-1:0] r_ram_addr, r_buf_addr;
  assign w_req  = (w_st == REL) ? r_pending : (obj_copy | r_pending);
  assign w_last = r_ram_addr == LAST;
  jtcop_busreq u_busreq (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_last   (w_last),
    .i_asn    (ASn),
    .i_bgn    (BGn),
    .o_brn    (BRn),
    .o_bgackn (BGACKn),
    .o_st     (w_st)
  );
  // a trigger seen while REL consumes pending belongs to the next frame, so it is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_ram_addr <= '0;
      r_buf_addr <= '0;
    end else begin
      r_pending  <= (w_st == IDLE) ? 1'b0 : (w_st == REL) ? obj_copy : (r_pending | obj_copy);
      r_ram_addr <= (w_st == REQ) ? '0 :
                    ((w_st == GRANT || w_st == COPY) && !w_last) ? r_ram_addr + 1'b1 : r_ram_addr;
      r_buf_addr <= r_ram_addr;
    end
  end
  assign ram_addr = r_ram_addr;
  assign buf_addr = r_buf_addr;
  assign buf_we   = w_st == COPY || w_st == FLUSH;
  assign buf_din  = buf_we ? ram_dout : 16'h0;
  assign busy     = w_st != IDLE;
  assign done     = w_st == REL;
endmodule

// File: tb/tb_jtcop_objdma.sv
// tb_jtcop_objdma: scoreboard bench for the object RAM DMA, full-size and LEN=4 builds
module tb_jtcop_objdma;
  logic clk = 0, rst = 1, obj_copy = 0, ASn = 1, BGn = 1;
  logic BRn, BGACKn, buf_we, busy, done;
  logic [9:0] ram_addr, buf_addr;
  logic [15:0] ram_dout = 0, buf_din;
  logic s_copy = 0, s_asn = 1, s_bgn = 0;
  logic s_brn, s_bgackn, s_we, s_busy, s_done;
  logic [9:0] s_ram_addr, s_buf_addr;
  logic [15:0] s_dout = 0, s_din;
  logic [31:0] sb[$], sb_s[$];
  logic [31:0] e_m, e_s;
  int n_chk = 0, n_err = 0;
  int n_wr = 0, n_done = 0, bg_run = 0, last_run = 0, n_ovl = 0;
  int s_nwr = 0, s_run = 0, s_last_run = 0, s_max = 0;
  int b_wr, b_done, b_ovl;
  always #5 clk = ~clk;
  jtcop_objdma #(.AW(10), .LEN(1024)) u_dut (
    .clk(clk), .rst(rst), .obj_copy(obj_copy), .ASn(ASn), .BGn(BGn), .BRn(BRn), .BGACKn(BGACKn),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .buf_addr(buf_addr), .buf_din(buf_din),
    .buf_we(buf_we), .busy(busy), .done(done)
  );
  jtcop_objdma #(.AW(10), .LEN(4)) u_small (
    .clk(clk), .rst(rst), .obj_copy(s_copy), .ASn(s_asn), .BGn(s_bgn), .BRn(s_brn), .BGACKn(s_bgackn),
    .ram_addr(s_ram_addr), .ram_dout(s_dout), .buf_addr(s_buf_addr), .buf_din(s_din),
    .buf_we(s_we), .busy(s_busy), .done(s_done)
  );
  function automatic logic [15:0] pat(input int i);
    return 16'(i) ^ 16'hA5A5;
  endfunction
  always @(posedge clk) begin
    ram_dout <= pat(int'(ram_addr));
    s_dout   <= pat(int'(s_ram_addr));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (buf_we) begin
      n_wr++;
      chk("wr_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e_m = sb.pop_front();
        chk("wr_addr", buf_addr, e_m[31:16]);
        chk("wr_data", buf_din, e_m[15:0]);
      end
    end
    if (!BGACKn) bg_run++;
    else if (bg_run != 0) begin
      last_run = bg_run;
      bg_run = 0;
    end
    if (!BGACKn && !BRn) n_ovl++;
    if (done) n_done++;
  end
  always @(negedge clk) begin
    if (s_we) begin
      s_nwr++;
      chk("s_wr_expected", sb_s.size() > 0, 1);
      if (sb_s.size() > 0) begin
        e_s = sb_s.pop_front();
        chk("s_wr_addr", s_buf_addr, e_s[31:16]);
        chk("s_wr_data", s_din, e_s[15:0]);
      end
    end
    if (!s_bgackn) s_run++;
    else if (s_run != 0) begin
      s_last_run = s_run;
      s_run = 0;
    end
    if (int'(s_ram_addr) > s_max) s_max = int'(s_ram_addr);
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic trig();
    obj_copy = 1;
    tick(1);
    obj_copy = 0;
  endtask
  task automatic push_xfer();
    for (int i = 0; i < 1024; i++) sb.push_back({16'(i), pat(i)});
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 3000) begin
      tick(1);
      k++;
    end
    chk(tag, done, 1);
  endtask
  task automatic wait_wr(input int n);
    int k = 0;
    while (n_wr < n && k < 3000) begin
      tick(1);
      k++;
    end
    chk("wr_reach", n_wr >= n, 1);
  endtask
  task automatic snap();
    b_wr = n_wr;
    b_done = n_done;
    b_ovl = n_ovl;
  endtask
  initial begin
    tick(3);
    chk("rst_brn", BRn, 1);
    chk("rst_bgackn", BGACKn, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_buf_addr", buf_addr, 0);
    chk("rst_buf_din", buf_din, 0);
    chk("rst_buf_we", buf_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    tick(2);
    snap();
    push_xfer();
    trig();
    chk("req_brn", BRn, 0);
    chk("req_busy", busy, 1);
    tick(5);
    chk("req_bgackn", BGACKn, 1);
    BGn = 0;
    tick(1);
    chk("grant_bgackn", BGACKn, 0);
    chk("grant_brn", BRn, 0);
    chk("grant_we", buf_we, 0);
    chk("grant_ram_addr", ram_addr, 0);
    tick(1);
    chk("copy_we", buf_we, 1);
    chk("copy_brn", BRn, 1);
    chk("copy_buf_addr", buf_addr, 0);
    wait_done("basic_done_seen");
    tick(1);
    chk("basic_busy_after", busy, 0);
    chk("basic_done_pulse", done, 0);
    BGn = 1;
    tick(2);
    chk("basic_writes", n_wr - b_wr, 1024);
    chk("basic_dones", n_done - b_done, 1);
    chk("basic_bgack_len", last_run, 1026);
    chk("basic_overlap", n_ovl - b_ovl, 1);
    snap();
    push_xfer();
    BGn = 0;
    ASn = 0;
    trig();
    tick(8);
    chk("as_busy_bgackn", BGACKn, 1);
    chk("as_busy_brn", BRn, 0);
    chk("as_busy_writes", n_wr - b_wr, 0);
    ASn = 1;
    tick(1);
    chk("as_grant_bgackn", BGACKn, 0);
    wait_done("as_done_seen");
    tick(3);
    chk("as_writes", n_wr - b_wr, 1024);
    chk("as_bgack_len", last_run, 1026);
    snap();
    push_xfer();
    push_xfer();
    trig();
    wait_wr(b_wr + 100);
    repeat (3) begin
      trig();
      tick(10);
    end
    wait_done("pend_done1");
    tick(1);
    chk("pend_rereq_brn", BRn, 0);
    chk("pend_rereq_busy", busy, 1);
    wait_done("pend_done2");
    tick(1);
    chk("pend_idle_busy", busy, 0);
    tick(2);
    chk("pend_writes", n_wr - b_wr, 2048);
    chk("pend_dones", n_done - b_done, 2);
    snap();
    push_xfer();
    trig();
    wait_done("edge_done1");
    push_xfer();
    obj_copy = 1;
    tick(1);
    obj_copy = 0;
    wait_done("edge_done2");
    tick(20);
    chk("edge_idle_busy", busy, 0);
    chk("edge_dones", n_done - b_done, 2);
    chk("edge_writes", n_wr - b_wr, 2048);
    snap();
    push_xfer();
    trig();
    wait_wr(b_wr + 300);
    rst = 1;
    #1;
    chk("arst_brn", BRn, 1);
    chk("arst_bgackn", BGACKn, 1);
    chk("arst_we", buf_we, 0);
    chk("arst_busy", busy, 0);
    sb.delete();
    tick(3);
    chk("arst_writes", n_wr - b_wr, 300);
    rst = 0;
    tick(2);
    snap();
    push_xfer();
    trig();
    wait_done("restart_done");
    tick(3);
    chk("restart_writes", n_wr - b_wr, 1024);
    for (int i = 0; i < 4; i++) sb_s.push_back({16'(i), pat(i)});
    s_copy = 1;
    tick(1);
    s_copy = 0;
    for (int k = 0; k < 100 && !s_done; k++) tick(1);
    chk("small_done_seen", s_done, 1);
    tick(3);
    chk("small_writes", s_nwr, 4);
    chk("small_bgack_len", s_last_run, 6);
    chk("small_max_addr", s_max, 3);
    chk("small_sb_left", sb_s.size(), 0);
    chk("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
